ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter_if.sv | 45 ++++
 rtl/ram_arbiter.sv | 121 ++++++++++++
 tb/tb_ram_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two RAM masters, the ram_arbiter and the single-port RAM macro.
// The arbiter takes the slave modport; the masters plus the RAM side take the master modport.
interface ram_arbiter_if #(
   parameter int AW = 15,
   parameter int DW = 8
);
   logic          a_req;
   logic          a_we;
   logic [AW-1:0] a_addr;
   logic [DW-1:0] a_wdata;
   logic          a_gnt;
   logic          a_rvalid;
   logic [DW-1:0] a_rdata;

   logic          b_req;
   logic          b_we;
   logic [AW-1:0] b_addr;
   logic [DW-1:0] b_wdata;
   logic          b_gnt;
   logic          b_rvalid;
   logic [DW-1:0] b_rdata;

   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_din;
   logic          ram_we;
   logic [DW-1:0] ram_dout;

   modport slave (
      input  a_req, a_we, a_addr, a_wdata,
      output a_gnt, a_rvalid, a_rdata,
      input  b_req, b_we, b_addr, b_wdata,
      output b_gnt, b_rvalid, b_rdata,
      output ram_addr, ram_din, ram_we,
      input  ram_dout
   );

   modport master (
      output a_req, a_we, a_addr, a_wdata,
      input  a_gnt, a_rvalid, a_rdata,
      output b_req, b_we, b_addr, b_wdata,
      input  b_gnt, b_rvalid, b_rdata,
      input  ram_addr, ram_din, ram_we,
      output ram_dout
   );
endinterface

// File: rtl/ram_arbiter.sv
// Shares one single-port RAM between two masters with combinational grant and 1-cycle read return.
// Define ARB_RR_EN for round-robin-with-burst contention; default is fixed priority to port A.
module ram_arbiter #(
   parameter int AW    = 15,
   parameter int DW    = 8,
   parameter int BURST = 4
) (
   input  logic         clk,
   input  logic         rst,
   ram_arbiter_if.slave bus
);

   typedef enum logic {
      PORT_A = 1'b0,
      PORT_B = 1'b1
   } port_t;

   localparam logic [7:0] BURST_LAST = 8'(BURST - 1);

   port_t         sel;
   port_t         sel_nxt;
   port_t         rd_owner;
   logic [7:0]    cnt;
   logic [7:0]    cnt_nxt;
   logic          rd_pend;
   logic          a_gnt;
   logic          b_gnt;
   logic          a_rv;
   logic          b_rv;
   logic          rd_accept;
   logic [AW-1:0] addr_mux;
   logic [DW-1:0] din_mux;
   logic          we_mux;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sel      <= PORT_A;
         cnt      <= 8'd0;
         rd_pend  <= 1'b0;
         rd_owner <= PORT_A;
      end else begin
         sel     <= sel_nxt;
         cnt     <= cnt_nxt;
         rd_pend <= rd_accept;
         if (rd_accept) begin
            rd_owner <= sel_nxt;
         end
      end
   end

   // sel_nxt is the port granted this cycle, or the held sel when idle
   always_comb begin
      sel_nxt = sel;
      cnt_nxt = cnt;
      a_gnt   = 1'b0;
      b_gnt   = 1'b0;
      if (!rst) begin
         if (bus.a_req && bus.b_req) begin
`ifdef ARB_RR_EN
            if (cnt < BURST_LAST) begin
               sel_nxt = sel;
               cnt_nxt = cnt + 8'd1;
            end else begin
               sel_nxt = (sel == PORT_A) ? PORT_B : PORT_A;
               cnt_nxt = 8'd0;
            end
`else
            sel_nxt = PORT_A;
            cnt_nxt = 8'd0;
`endif
            a_gnt = (sel_nxt == PORT_A);
            b_gnt = (sel_nxt == PORT_B);
         end else if (bus.a_req) begin
            sel_nxt = PORT_A;
            cnt_nxt = 8'd0;
            a_gnt   = 1'b1;
         end else if (bus.b_req) begin
            sel_nxt = PORT_B;
            cnt_nxt = 8'd0;
            b_gnt   = 1'b1;
         end
      end
   end

`ifndef ARB_RR_EN
   logic unused_burst;
   assign unused_burst = ^BURST_LAST;
`endif

   // Idle cycles keep the last granted port's address on the RAM to avoid toggling
   always_comb begin
      addr_mux = '0;
      din_mux  = '0;
      we_mux   = 1'b0;
      if (!rst) begin
         if (sel_nxt == PORT_B) begin
            addr_mux = bus.b_addr;
            din_mux  = bus.b_wdata;
         end else begin
            addr_mux = bus.a_addr;
            din_mux  = bus.a_wdata;
         end
         we_mux = (a_gnt & bus.a_we) | (b_gnt & bus.b_we);
      end
   end

   assign rd_accept = (a_gnt & ~bus.a_we) | (b_gnt & ~bus.b_we);
   assign a_rv      = rd_pend && (rd_owner == PORT_A);
   assign b_rv      = rd_pend && (rd_owner == PORT_B);

   assign bus.a_gnt    = a_gnt;
   assign bus.b_gnt    = b_gnt;
   assign bus.a_rvalid = a_rv;
   assign bus.b_rvalid = b_rv;
   assign bus.a_rdata  = a_rv ? bus.ram_dout : '0;
   assign bus.b_rdata  = b_rv ? bus.ram_dout : '0;
   assign bus.ram_addr = addr_mux;
   assign bus.ram_din  = din_mux;
   assign bus.ram_we   = we_mux;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios plus randomized traffic
// scored against a transaction-level model of the grant rules and RAM contents.
module tb_ram_arbiter;

   localparam int AW    = 15;
   localparam int DW    = 8;
   localparam int BURST = 4;
   localparam int DEPTH = 1 << AW;

   logic clk = 1'b0;
   logic rst;
   int   tests_run = 0;
   int   failures  = 0;

   always #5 clk = ~clk;

   ram_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   ram_arbiter #(.AW(AW), .DW(DW), .BURST(BURST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // RAM macro: registered read, read-before-write
   logic [DW-1:0] ram_mem [0:DEPTH-1];
   always @(posedge clk) begin
      if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
      bus.ram_dout <= ram_mem[bus.ram_addr];
   end

   // Reference model: who should win, what memory holds, which read returns next cycle
   logic [DW-1:0] shadow [0:DEPTH-1];
   bit            last_b   = 1'b0;
   int            streak   = 0;
   bit            exp_rv_a = 1'b0;
   bit            exp_rv_b = 1'b0;
   logic [DW-1:0] exp_rd   = '0;
   logic [1:0]    m_g;
   bit            m_we;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_data;

   function automatic logic [1:0] model_grant();
      if (rst) return 2'b00;
      if (bus.a_req && bus.b_req) begin
`ifdef ARB_RR_EN
         if (streak < BURST - 1) return last_b ? 2'b10 : 2'b01;
         return last_b ? 2'b01 : 2'b10;
`else
         return 2'b01;
`endif
      end
      return {bus.b_req, bus.a_req};
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         last_b   = 1'b0;
         streak   = 0;
         exp_rv_a = 1'b0;
         exp_rv_b = 1'b0;
         exp_rd   = '0;
      end else begin
         m_g      = model_grant();
         exp_rv_a = 1'b0;
         exp_rv_b = 1'b0;
         if (m_g != 2'b00) begin
            if (bus.a_req && bus.b_req && (m_g[1] == last_b)) streak = streak + 1;
            else streak = 0;
            last_b = m_g[1];
            m_we   = m_g[1] ? bus.b_we    : bus.a_we;
            m_addr = m_g[1] ? bus.b_addr  : bus.a_addr;
            m_data = m_g[1] ? bus.b_wdata : bus.a_wdata;
            if (m_we) begin
               shadow[m_addr] = m_data;
            end else begin
               exp_rd = shadow[m_addr];
               if (m_g[1]) exp_rv_b = 1'b1;
               else exp_rv_a = 1'b1;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst         = 1'b1;
      bus.a_req   = 1'b1;
      bus.a_we    = 1'b1;
      bus.a_addr  = 15'h0003;
      bus.a_wdata = 8'hFF;
      bus.b_req   = 1'b1;
      bus.b_we    = 1'b1;
      bus.b_addr  = 15'h0005;
      bus.b_wdata = 8'hEE;
      @(negedge clk);
      tests_run++;
      if ({bus.a_gnt, bus.b_gnt, bus.ram_we, bus.a_rvalid, bus.b_rvalid} !== 5'b0) begin
         failures++;
         $display("[TB] FAIL reset_ctrl: got %b expected 00000",
                  {bus.a_gnt, bus.b_gnt, bus.ram_we, bus.a_rvalid, bus.b_rvalid});
      end
      tests_run++;
      if (bus.ram_addr !== '0 || bus.ram_din !== '0) begin
         failures++;
         $display("[TB] FAIL reset_ram_bus: got addr %0h din %0h expected 0 0", bus.ram_addr, bus.ram_din);
      end
      tests_run++;
      if (bus.a_rdata !== '0 || bus.b_rdata !== '0) begin
         failures++;
         $display("[TB] FAIL reset_rdata: got %0h %0h expected 0 0", bus.a_rdata, bus.b_rdata);
      end
      // Start a port-A read, then hit reset while its rvalid is showing
      @(posedge clk);
      #1;
      rst       = 1'b0;
      bus.b_req = 1'b0;
      bus.a_we  = 1'b0;
      tick();
      bus.a_req = 1'b0;
      tests_run++;
      if (bus.a_rvalid !== 1'b1) begin
         failures++;
         $display("[TB] FAIL reset_pre_rvalid: got %b expected 1", bus.a_rvalid);
      end
      bus.a_req = 1'b1;
      rst       = 1'b1;
      #1;
      tests_run++;
      if ({bus.a_rvalid, bus.b_rvalid, bus.a_gnt, bus.ram_we} !== 4'b0 || bus.a_rdata !== '0 || bus.ram_addr !== '0) begin
         failures++;
         $display("[TB] FAIL reset_async: got rv/gnt/we %b rdata %0h addr %0h expected 0000 0 0",
                  {bus.a_rvalid, bus.b_rvalid, bus.a_gnt, bus.ram_we}, bus.a_rdata, bus.ram_addr);
      end
      bus.a_req = 1'b0;
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         tests_run++;
         if ({bus.a_rvalid, bus.b_rvalid} !== 2'b00) begin
            failures++;
            $display("[TB] FAIL reset_no_rvalid[%0d]: got %b expected 00", i, {bus.a_rvalid, bus.b_rvalid});
         end
      end
   endtask

   task automatic test_single_a();
      tick();
      bus.a_req   = 1'b1;
      bus.a_we    = 1'b1;
      bus.a_addr  = 15'h0010;
      bus.a_wdata = 8'h5A;
      @(negedge clk);
      tests_run++;
      if ({bus.a_gnt, bus.b_gnt, bus.ram_we} !== 3'b101 || bus.ram_addr !== 15'h0010 || bus.ram_din !== 8'h5A) begin
         failures++;
         $display("[TB] FAIL single_write: got gnt/we %b addr %0h din %0h expected 101 10 5a",
                  {bus.a_gnt, bus.b_gnt, bus.ram_we}, bus.ram_addr, bus.ram_din);
      end
      tick();
      bus.a_we = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus.a_gnt, bus.ram_we, bus.a_rvalid} !== 3'b100) begin
         failures++;
         $display("[TB] FAIL single_read_issue: got gnt/we/rvalid %b expected 100",
                  {bus.a_gnt, bus.ram_we, bus.a_rvalid});
      end
      tick();
      bus.a_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 8'h5A || bus.b_rvalid !== 1'b0 || bus.b_rdata !== 8'h00) begin
         failures++;
         $display("[TB] FAIL single_read_data: got a %b/%0h b %b/%0h expected a 1/5a b 0/0",
                  bus.a_rvalid, bus.a_rdata, bus.b_rvalid, bus.b_rdata);
      end
   endtask

   task automatic test_interleave();
      tick();
      bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 15'h0001; bus.a_wdata = 8'h11;
      tick();
      bus.a_req = 1'b0;
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 15'h0002; bus.b_wdata = 8'h22;
      tick();
      bus.b_req = 1'b0;
      bus.a_req = 1'b1; bus.a_we = 1'b0;
      tick();
      bus.a_req = 1'b0;
      bus.b_req = 1'b1; bus.b_we = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.a_rvalid !== 1'b1 || bus.a_rdata !== 8'h11 || bus.b_rvalid !== 1'b0 || bus.b_rdata !== 8'h00) begin
         failures++;
         $display("[TB] FAIL interleave_a: got a %b/%0h b %b/%0h expected a 1/11 b 0/0",
                  bus.a_rvalid, bus.a_rdata, bus.b_rvalid, bus.b_rdata);
      end
      tick();
      bus.b_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if (bus.b_rvalid !== 1'b1 || bus.b_rdata !== 8'h22 || bus.a_rvalid !== 1'b0 || bus.a_rdata !== 8'h00) begin
         failures++;
         $display("[TB] FAIL interleave_b: got b %b/%0h a %b/%0h expected b 1/22 a 0/0",
                  bus.b_rvalid, bus.b_rdata, bus.a_rvalid, bus.a_rdata);
      end
   endtask

   task automatic test_contention();
      logic [1:0] exp;
      tick();
      bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 15'h0020; bus.a_wdata = 8'hA0;
      bus.b_req = 1'b1; bus.b_we = 1'b1; bus.b_addr = 15'h0021; bus.b_wdata = 8'hB0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
`ifdef ARB_RR_EN
         exp = model_grant();
`else
         exp = 2'b01;
`endif
         tests_run++;
         if ({bus.b_gnt, bus.a_gnt} !== exp) begin
            failures++;
            $display("[TB] FAIL contention[%0d]: got b/a gnt %b expected %b", i, {bus.b_gnt, bus.a_gnt}, exp);
         end
         tick();
      end
      bus.a_req = 1'b0;
      @(negedge clk);
      tests_run++;
      if ({bus.b_gnt, bus.a_gnt} !== 2'b10) begin
         failures++;
         $display("[TB] FAIL contention_release: got b/a gnt %b expected 10", {bus.b_gnt, bus.a_gnt});
      end
      tick();
      bus.b_req = 1'b0;
   endtask

   task automatic test_idle();
      bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 15'h0123; bus.a_wdata = 8'h77;
      @(negedge clk);
      tests_run++;
      if (bus.a_gnt !== 1'b1 || bus.ram_addr !== 15'h0123) begin
         failures++;
         $display("[TB] FAIL idle_write: got gnt %b addr %0h expected 1 123", bus.a_gnt, bus.ram_addr);
      end
      tick();
      bus.a_req = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         tests_run++;
         if ({bus.ram_we, bus.a_gnt, bus.b_gnt} !== 3'b000 || bus.ram_addr !== 15'h0123) begin
            failures++;
            $display("[TB] FAIL idle[%0d]: got we/gnt %b addr %0h expected 000 123",
                     i, {bus.ram_we, bus.a_gnt, bus.b_gnt}, bus.ram_addr);
         end
         tick();
      end
   endtask

   task automatic test_random();
      bit            a_took = 1'b1;
      bit            b_took = 1'b1;
      logic [1:0]    exp;
      logic [AW-1:0] exp_addr;
      logic [DW-1:0] exp_din;
      bit            exp_we;
      for (int cyc = 0; cyc < 400; cyc++) begin
         if (!bus.a_req || a_took) begin
            bus.a_req   = ($urandom_range(0, 3) != 0);
            bus.a_we    = 1'($urandom_range(0, 1));
            bus.a_addr  = AW'($urandom_range(0, 7));
            bus.a_wdata = DW'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            bus.a_req = 1'b0;
         end
         if (!bus.b_req || b_took) begin
            bus.b_req   = ($urandom_range(0, 3) != 0);
            bus.b_we    = 1'($urandom_range(0, 1));
            bus.b_addr  = AW'($urandom_range(0, 7));
            bus.b_wdata = DW'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            bus.b_req = 1'b0;
         end
         @(negedge clk);
         exp    = model_grant();
         a_took = exp[0];
         b_took = exp[1];
         tests_run++;
         if ({bus.b_gnt, bus.a_gnt} !== exp) begin
            failures++;
            $display("[TB] FAIL rand_gnt@%0d: got b/a %b expected %b", cyc, {bus.b_gnt, bus.a_gnt}, exp);
         end
         tests_run++;
         if (bus.a_rvalid !== exp_rv_a || bus.a_rdata !== (exp_rv_a ? exp_rd : 8'h00)) begin
            failures++;
            $display("[TB] FAIL rand_a_read@%0d: got %b/%0h expected %b/%0h", cyc,
                     bus.a_rvalid, bus.a_rdata, exp_rv_a, exp_rv_a ? exp_rd : 8'h00);
         end
         tests_run++;
         if (bus.b_rvalid !== exp_rv_b || bus.b_rdata !== (exp_rv_b ? exp_rd : 8'h00)) begin
            failures++;
            $display("[TB] FAIL rand_b_read@%0d: got %b/%0h expected %b/%0h", cyc,
                     bus.b_rvalid, bus.b_rdata, exp_rv_b, exp_rv_b ? exp_rd : 8'h00);
         end
         if (exp != 2'b00) begin
            exp_we   = exp[1] ? bus.b_we    : bus.a_we;
            exp_addr = exp[1] ? bus.b_addr  : bus.a_addr;
            exp_din  = exp[1] ? bus.b_wdata : bus.a_wdata;
            tests_run++;
            if (bus.ram_we !== exp_we || bus.ram_addr !== exp_addr || bus.ram_din !== exp_din) begin
               failures++;
               $display("[TB] FAIL rand_ram@%0d: got we %b addr %0h din %0h expected %b %0h %0h", cyc,
                        bus.ram_we, bus.ram_addr, bus.ram_din, exp_we, exp_addr, exp_din);
            end
         end else begin
            tests_run++;
            if (bus.ram_we !== 1'b0) begin
               failures++;
               $display("[TB] FAIL rand_idle_we@%0d: got %b expected 0", cyc, bus.ram_we);
            end
         end
         tick();
      end
      bus.a_req = 1'b0;
      bus.b_req = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         ram_mem[i] = '0;
         shadow[i]  = '0;
      end
      bus.a_req = 1'b0; bus.a_we = 1'b0; bus.a_addr = '0; bus.a_wdata = '0;
      bus.b_req = 1'b0; bus.b_we = 1'b0; bus.b_addr = '0; bus.b_wdata = '0;
      test_reset();
      test_single_a();
      test_interleave();
      test_contention();
      test_idle();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule
